sid_bus_arbiter: RTL and testbench
==================================

Name: sid_bus_arbiter

Overview:
- Shares the single SID register port (we/addr/data_in/data_out of the sid8580 core) between two requesters: the C64 CPU bus and a host player interface (e.g. an ESP32 streaming SID register dumps).
- Host writes are buffered in a small FIFO and paced at one write per ce_1m tick. CPU accesses always win.
- A clear sequencer zeroes all 25 writable SID registers on request.
- Sits between the bus decode/host bridge and the sid8580 instance.

Parameters:
- FIFO_AW, 3, log2 of host FIFO depth (depth = 2**FIFO_AW = 8 entries).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce_1m  in  1  1 MHz SID clock enable, one clk wide.
- cpu_cs  in  1  CPU selects SID this cycle.
- cpu_we  in  1  CPU write (qualified by cpu_cs).
- cpu_addr  in  5  CPU register address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- host_valid  in  1  host write request.
- host_ready  out  1  host write accepted when valid&ready.
- host_addr  in  5  host register address.
- host_data  in  8  host write data.
- clear_req  in  1  one-cycle pulse to start the clear sequence.
- clear_busy  out  1  clear sequence in progress.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- sid_we  out  1  to SID we.
- sid_addr  out  5  to SID addr.
- sid_din  out  8  to SID data_in.
- sid_dout  in  8  from SID data_out.

Behaviour:
- Reset values:
  - Outputs: sid_we=0, sid_addr=0, sid_din=0, clear_busy=0, fifo_level=0.
  - FIFO pointers are 0.
  - host_ready=1 on the first cycle after reset deasserts.
- Registered outputs: sid_we, sid_addr and sid_din are registered. A write decided in cycle N appears on the SID port in cycle N+1 for exactly one clk.
- Slot arbiter, evaluated every clk in fixed priority:
  1. CPU write: cpu_cs&cpu_we issues {cpu_addr,cpu_din} unconditionally, independent of ce_1m.
  2. Clear sequencer write: only when ce_1m=1 and no CPU write this cycle.
  3. FIFO pop: only when ce_1m=1, no CPU write, clear idle, FIFO non-empty.
  - A source that loses the slot holds its pending write until the next eligible ce_1m; nothing is dropped.
- Read path:
  - When no write is issued, sid_addr <= cpu_addr every cycle and sid_we <= 0.
  - cpu_dout = sid_dout (combinational), valid one clk after cpu_addr is presented.
  - CPU reads never stall host traffic except through address ownership of the issuing cycle.
- FIFO:
  - Depth 2**FIFO_AW, width 13 ({addr,data}).
  - Push when host_valid & host_ready.
  - host_ready = !full & !clear_busy.
  - Simultaneous push and pop is allowed; level is unchanged.
  - Pointers wrap modulo depth; fifo_level distinguishes full from empty.
  - Pop on empty never occurs.
- Clear sequencer, states IDLE -> CLEAR -> IDLE:
  - On clear_req in IDLE: flush the FIFO (level=0), set clear_busy, load index=0. A host push in that same cycle is discarded, because flush wins.
  - In CLEAR, each won slot issues {index,8'h00} and increments index.
  - After index 24 (5'h18) is issued, return to IDLE and drop clear_busy in the following cycle.
  - clear_req while busy is ignored.
  - CPU writes during CLEAR still issue; the sequence continues afterwards.
  - The full sequence takes 25 ce_1m ticks when uncontested.
- Reset mid-operation: any state returns to IDLE, FIFO is emptied, and any pending write is discarded. No partial SID write is emitted after reset.
- Host writes to addresses 0x19-0x1F are passed through unchanged; the SID ignores them.

Test Plan:
- Reset, then host pushes {0x18,0x0F}: host_ready=1, fifo_level=1, and on the next ce_1m sid_we pulses for one clk with sid_addr=0x18, sid_din=0x0F; fifo_level returns to 0.
- Host pushes 9 writes with no ce_1m: 8 are accepted, host_ready=0 at fifo_level=8, and the 9th is held by the host. Then 8 ce_1m ticks produce 8 SID writes in push order.
- CPU write {0x04,0x41} in the same cycle as ce_1m with the FIFO non-empty: the CPU write is issued next clk, the FIFO entry is issued at the following ce_1m, and fifo_level decrements only then.
- clear_req with 3 entries queued: fifo_level=0 immediately, clear_busy=1, and SID receives addr 0x00..0x18 with data 0x00 on 25 consecutive ce_1m ticks; clear_busy falls afterwards and host_ready=1.
- CPU read of addr 0x1B with sid_dout=0xA5: sid_addr=0x1B one clk later, cpu_dout=0xA5, sid_we stays 0.
- Assert reset during CLEAR at index 10: after reset, clear_busy=0, fifo_level=0, and no further SID writes occur.

Source files
------------

// File: rtl/sid_bus_arbiter.sv
// sid_bus_arbiter: shares the SID register port between the CPU bus, a paced host write FIFO and a clear sequencer
module sid_bus_arbiter #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_1m,
  input  logic               cpu_cs,
  input  logic               cpu_we,
  input  logic [4:0]         cpu_addr,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [4:0]         host_addr,
  input  logic [7:0]         host_data,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               sid_we,
  output logic [4:0]         sid_addr,
  output logic [7:0]         sid_din,
  input  logic [7:0]         sid_dout
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [12:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] level;
  logic [4:0] index, index_n;
  logic cpu_wr, clr_wr, pop, push, start;
  assign fifo_level = level;
  assign clear_busy = state == CLEAR;
  // level MSB is set only when all 2**FIFO_AW entries are occupied
  assign host_ready = !level[FIFO_AW] & !clear_busy;
  assign cpu_dout = sid_dout;
  always_comb begin
    cpu_wr = cpu_cs & cpu_we;
    start = clear_req & (state == IDLE);
    clr_wr = !cpu_wr & ce_1m & (state == CLEAR);
    pop = !cpu_wr & ce_1m & (state == IDLE) & !clear_req & (level != '0);
    push = host_valid & host_ready & !start;
    state_n = start ? CLEAR : (clr_wr && index == 5'h18) ? IDLE : state;
    index_n = start ? 5'd0 : clr_wr ? index + 5'd1 : index;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      sid_we <= 1'b0;
      sid_addr <= '0;
      sid_din <= '0;
    end else begin
      state <= state_n;
      index <= index_n;
      sid_we <= cpu_wr | clr_wr | pop;
      sid_addr <= cpu_wr ? cpu_addr : clr_wr ? index : pop ? mem[rd_ptr][12:8] : cpu_addr;
      sid_din <= cpu_wr ? cpu_din : pop ? mem[rd_ptr][7:0] : 8'h00;
      if (start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        level <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {host_addr, host_data};
endmodule

// File: tb/tb_sid_bus_arbiter.sv
// tb_sid_bus_arbiter: scoreboard bench with a queue-based reference model of the SID port arbiter
module tb_sid_bus_arbiter;
  logic clk = 0, reset = 1, ce_1m = 0, cpu_cs = 0, cpu_we = 0, host_valid = 0, clear_req = 0;
  logic [4:0] cpu_addr = 0, host_addr = 0;
  logic [7:0] cpu_din = 0, host_data = 0, sid_dout = 0;
  logic [7:0] cpu_dout, sid_din;
  logic [4:0] sid_addr;
  logic [3:0] fifo_level;
  logic host_ready, clear_busy, sid_we;
  sid_bus_arbiter #(.FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .clear_req(clear_req), .clear_busy(clear_busy), .fifo_level(fifo_level),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_din(sid_din), .sid_dout(sid_dout)
  );
  always #5 clk = ~clk;
  typedef struct {int due; bit we; bit [4:0] a; bit [7:0] d;} exp_t;
  exp_t sb[$];
  bit [12:0] mq[$];
  bit mbusy = 0;
  int midx = 0;
  int errors = 0, checks = 0, cyc = 0;
  bit did_rst = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("slot_cycle", cyc, e.due);
      chk("sid_we", sid_we, e.we);
      chk("sid_addr", sid_addr, e.a);
      if (e.we) chk("sid_din", sid_din, e.d);
    end
  // reference: CPU write first, then clear sequence, then FIFO, each only on its allowed ticks
  task automatic step();
    exp_t e;
    bit ready, start;
    e.due = cyc + 1;
    e.we = 1;
    e.d = 0;
    if (reset) begin
      mq.delete();
      mbusy = 0;
      midx = 0;
      e.we = 0;
      e.a = 0;
    end else begin
      ready = mq.size() < 8 && !mbusy;
      start = clear_req && !mbusy;
      if (cpu_cs && cpu_we) begin
        e.a = cpu_addr;
        e.d = cpu_din;
      end else if (ce_1m && mbusy) begin
        e.a = midx[4:0];
        midx++;
        if (midx == 25) mbusy = 0;
      end else if (ce_1m && !start && mq.size() > 0) begin
        {e.a, e.d} = mq.pop_front();
      end else begin
        e.we = 0;
        e.a = cpu_addr;
      end
      if (host_valid && ready && !start) mq.push_back({host_addr, host_data});
      if (start) begin
        mq.delete();
        mbusy = 1;
        midx = 0;
      end
    end
    sb.push_back(e);
  endtask
  task automatic tick(bit r, bit ce, bit cs, bit we, bit [4:0] ca, bit [7:0] cd,
                      bit hv, bit [4:0] ha, bit [7:0] hd, bit cl);
    @(negedge clk);
    chk("fifo_level", fifo_level, mq.size());
    chk("clear_busy", clear_busy, mbusy);
    chk("host_ready", host_ready, mq.size() < 8 && !mbusy);
    sid_dout = 8'($urandom);
    #1 chk("cpu_dout", cpu_dout, sid_dout);
    reset = r; ce_1m = ce; cpu_cs = cs; cpu_we = we; cpu_addr = ca; cpu_din = cd;
    host_valid = hv; host_addr = ha; host_data = hd; clear_req = cl;
    step();
  endtask
  initial begin
    step();
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 5'h18, 8'h0F, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 0, 0, 1, 5'(i), 8'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 5'h07, 8'h99, 0);
    tick(0, 1, 1, 1, 5'h04, 8'h41, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 1, 5'(i + 1), 8'hEE, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 5'h1F, 8'h55, 1);
    for (int i = 0; i < 27; i++) tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 5'h1B, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 5'h1B, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      bit r;
      r = ($urandom_range(299) == 0) || (mbusy && midx == 10 && !did_rst);
      if (mbusy && midx == 10) did_rst = 1;
      tick(r, $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
           5'($urandom), 8'($urandom), $urandom_range(1) == 1, 5'($urandom), 8'($urandom),
           $urandom_range(39) == 0);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
